// File: rtl/osd_pkg.sv
// Shared definitions for the OSD text writer and the overlay that reads its character RAM.
package osd_pkg;

    typedef enum logic [2:0] {
        CLEAR_INIT,
        IDLE,
        CLEAR,
        SCROLL_RD,
        SCROLL_WR,
        SCROLL_CLR
    } osd_state_t;

    localparam logic [7:0] CC_LF = 8'h0A;
    localparam logic [7:0] CC_CR = 8'h0D;
    localparam logic [7:0] CC_BS = 8'h08;
    localparam logic [7:0] CC_FF = 8'h0C;

    localparam int DEF_SCREEN_COLS = 40;
    localparam int DEF_SCREEN_ROWS = 30;
    localparam int DEF_ADDR_W      = 11;

    localparam logic [7:0] DEF_BLANK_CHAR = 8'h20;

endpackage

// File: rtl/osd_show_timer.sv
// Frame-counted show timer: show_req (re)loads the count, each vblank rising edge decrements it.
module osd_show_timer #(
    parameter int SHOW_FRAMES = 180
) (
    input  logic clk,
    input  logic reset_n,
    input  logic vblank,
    input  logic show_req,
    output logic osd_active
);

    localparam int CNT_W = (SHOW_FRAMES > 0) ? $clog2(SHOW_FRAMES + 1) : 1;

    logic             vblank_q;
    logic             vblank_rise;
    logic [CNT_W-1:0] frame_cnt;

    assign vblank_rise = vblank & ~vblank_q;

    // A load takes priority over a coincident vblank edge so a retrigger never loses a frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vblank_q   <= 1'b0;
            frame_cnt  <= '0;
            osd_active <= 1'b0;
        end else begin
            vblank_q <= vblank;
            if (show_req) begin
                frame_cnt <= CNT_W'(SHOW_FRAMES);
            end else if (vblank_rise && (frame_cnt != '0)) begin
                frame_cnt <= frame_cnt - CNT_W'(1);
            end
            osd_active <= (frame_cnt != '0);
        end
    end

endmodule

// File: rtl/osd_text_writer.sv
// Byte-stream text writer for the OSD character RAM: cursor handling, screen clear and one-row scroll.
module osd_text_writer
    import osd_pkg::*;
#(
    parameter int         SCREEN_COLS = DEF_SCREEN_COLS,
    parameter int         SCREEN_ROWS = DEF_SCREEN_ROWS,
    parameter int         ADDR_W      = DEF_ADDR_W,
    parameter logic [7:0] BLANK_CHAR  = DEF_BLANK_CHAR,
    parameter int         SHOW_FRAMES = 180
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic [ADDR_W-1:0] ram_addr_a,
    output logic              ram_we_a,
    output logic [7:0]        ram_wdata_a,
    input  logic [7:0]        ram_rdata_a,
    input  logic              vblank,
    input  logic              show_req,
    output logic              osd_active,
    output logic [5:0]        cursor_col,
    output logic [4:0]        cursor_row,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(SCREEN_COLS);
    localparam logic [ADDR_W-1:0] LAST_CELL  = ADDR_W'(SCREEN_COLS * SCREEN_ROWS - 1);
    localparam logic [ADDR_W-1:0] LAST_MOVE  = ADDR_W'(SCREEN_COLS * (SCREEN_ROWS - 1) - 1);
    localparam logic [ADDR_W-1:0] LAST_ROW_0 = ADDR_W'(SCREEN_COLS * (SCREEN_ROWS - 1));
    localparam logic [5:0]        LAST_COL   = 6'(SCREEN_COLS - 1);
    localparam logic [4:0]        LAST_ROW   = 5'(SCREEN_ROWS - 1);

    osd_state_t        state, state_next;
    logic [ADDR_W-1:0] idx, idx_next;
    logic [ADDR_W-1:0] addr_next;
    logic [ADDR_W-1:0] cursor_addr;
    logic [5:0]        col_next;
    logic [4:0]        row_next;
    logic              we_next;
    logic [7:0]        wdata_q, wdata_next;
    logic              copy_sel, copy_sel_next;
    logic              advance_row;
    logic              accept;

    assign in_ready    = (state == IDLE);
    assign busy        = (state != IDLE);
    assign accept      = in_valid & in_ready;
    assign cursor_addr = ADDR_W'(cursor_row) * ROW_STRIDE + ADDR_W'(cursor_col);

    // During a scroll write the data comes straight from the read issued the cycle before.
    assign ram_wdata_a = copy_sel ? ram_rdata_a : wdata_q;

    always_comb begin
        state_next    = state;
        idx_next      = idx;
        col_next      = cursor_col;
        row_next      = cursor_row;
        addr_next     = ram_addr_a;
        we_next       = 1'b0;
        wdata_next    = wdata_q;
        copy_sel_next = 1'b0;
        advance_row   = 1'b0;

        case (state)
            IDLE: begin
                if (accept) begin
                    case (in_data)
                        CC_LF: begin
                            col_next    = '0;
                            advance_row = 1'b1;
                        end
                        CC_CR: col_next = '0;
                        CC_BS: begin
                            if (cursor_col != '0) col_next = cursor_col - 6'd1;
                        end
                        CC_FF: begin
                            state_next = CLEAR;
                            idx_next   = '0;
                            col_next   = '0;
                            row_next   = '0;
                        end
                        default: begin
                            addr_next  = cursor_addr;
                            we_next    = 1'b1;
                            wdata_next = in_data;
                            if (cursor_col == LAST_COL) begin
                                col_next    = '0;
                                advance_row = 1'b1;
                            end else begin
                                col_next = cursor_col + 6'd1;
                            end
                        end
                    endcase
                end
            end
            CLEAR_INIT, CLEAR, SCROLL_CLR: begin
                addr_next  = idx;
                we_next    = 1'b1;
                wdata_next = BLANK_CHAR;
                if (idx == LAST_CELL) begin
                    state_next = IDLE;
                    idx_next   = '0;
                end else begin
                    idx_next = idx + ADDR_W'(1);
                end
            end
            SCROLL_RD: begin
                addr_next  = idx + ROW_STRIDE;
                state_next = SCROLL_WR;
            end
            SCROLL_WR: begin
                addr_next     = idx;
                we_next       = 1'b1;
                copy_sel_next = 1'b1;
                if (idx == LAST_MOVE) begin
                    state_next = SCROLL_CLR;
                    idx_next   = LAST_ROW_0;
                end else begin
                    state_next = SCROLL_RD;
                    idx_next   = idx + ADDR_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase

        // The printable write is registered on this same edge, so it lands before the first scroll read.
        if (advance_row) begin
            if (cursor_row == LAST_ROW) begin
                state_next = SCROLL_RD;
                idx_next   = '0;
            end else begin
                row_next = cursor_row + 5'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= CLEAR_INIT;
            idx        <= '0;
            cursor_col <= '0;
            cursor_row <= '0;
            ram_addr_a <= '0;
            ram_we_a   <= 1'b0;
            wdata_q    <= '0;
            copy_sel   <= 1'b0;
        end else begin
            state      <= state_next;
            idx        <= idx_next;
            cursor_col <= col_next;
            cursor_row <= row_next;
            ram_addr_a <= addr_next;
            ram_we_a   <= we_next;
            wdata_q    <= wdata_next;
            copy_sel   <= copy_sel_next;
        end
    end

    osd_show_timer #(
        .SHOW_FRAMES(SHOW_FRAMES)
    ) u_show_timer (
        .clk       (clk),
        .reset_n   (reset_n),
        .vblank    (vblank),
        .show_req  (show_req),
        .osd_active(osd_active)
    );

endmodule
